// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with pixel CE, registered blanking/syncs/RGB and line/frame strobes.
// Define VTG_CSYNC_EN to add the composite sync output CSYN.
module video_timing_gen #(
  parameter int CNT_W       = 9,
  parameter int H_TOTAL     = 384,
  parameter int H_ACT_START = 16,
  parameter int H_ACT_END   = 272,
  parameter int V_TOTAL     = 264,
  parameter int V_ACT       = 224,
  parameter int H_SYNC_BASE = 288,
  parameter int H_SYNC_W    = 32,
  parameter int V_SYNC_BASE = 226,
  parameter int V_SYNC_W    = 4,
  parameter int RGB_W       = 12,
  parameter int HOFFS_W     = 5,
  parameter int VOFFS_W     = 3
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic               CE_PIX,
  input  logic [HOFFS_W-1:0] HOFFS,
  input  logic [VOFFS_W-1:0] VOFFS,
  input  logic [RGB_W-1:0]   iRGB,
  output logic [CNT_W-1:0]   HPOS,
  output logic [CNT_W-1:0]   VPOS,
  output logic [RGB_W-1:0]   oRGB,
  output logic               HBLK,
  output logic               VBLK,
  output logic               HSYN,
  output logic               VSYN,
  output logic               LINE_STB,
  output logic               FRAME_STB
`ifdef VTG_CSYNC_EN
  ,
  output logic               CSYN
`endif
);
  localparam int AW = CNT_W + 2;
  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic [HOFFS_W-1:0] r_hoffs_l;
  logic [VOFFS_W-1:0] r_voffs_l;
  logic [RGB_W-1:0] r_rgb;
  logic r_hblk, r_vblk, r_hsyn, r_vsyn, r_line_stb, r_frame_stb;
  logic w_h_last, w_v_last, w_hblk, w_vblk, w_hs_on, w_vs_on;
  logic [AW-1:0] w_h, w_v, w_hs_b, w_hd_sum, w_hd, w_vs_b, w_vd_sum, w_vd;
  assign w_h      = AW'(r_hcnt);
  assign w_v      = AW'(r_vcnt);
  assign w_h_last = w_h == AW'(H_TOTAL - 1);
  assign w_v_last = w_v == AW'(V_TOTAL - 1);
  assign w_hblk   = !(w_h >= AW'(H_ACT_START) && w_h < AW'(H_ACT_END));
  assign w_vblk   = !(w_v < AW'(V_ACT));
  // Sync windows are tested as the wrapped distance from the start, so pulses may straddle the counter wrap.
  assign w_hs_b   = (AW'(H_SYNC_BASE) + AW'({r_hoffs_l, 1'b0})) % AW'(H_TOTAL);
  assign w_hd_sum = w_h + AW'(H_TOTAL) - w_hs_b;
  assign w_hd     = w_hd_sum >= AW'(H_TOTAL) ? w_hd_sum - AW'(H_TOTAL) : w_hd_sum;
  assign w_hs_on  = w_hd < AW'(H_SYNC_W);
  assign w_vs_b   = (AW'(V_SYNC_BASE) + AW'({r_voffs_l, 2'b00})) % AW'(V_TOTAL);
  assign w_vd_sum = w_v + AW'(V_TOTAL) - w_vs_b;
  assign w_vd     = w_vd_sum >= AW'(V_TOTAL) ? w_vd_sum - AW'(V_TOTAL) : w_vd_sum;
  assign w_vs_on  = w_vd < AW'(V_SYNC_W);
`ifdef VTG_CSYNC_EN
  logic r_csyn;
  assign CSYN = r_csyn;
`endif
  always_ff @(posedge MCLK or posedge RESET)
    if (RESET) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_hoffs_l   <= '0;
      r_voffs_l   <= '0;
      r_rgb       <= '0;
      r_hblk      <= 1'b1;
      r_vblk      <= 1'b1;
      r_hsyn      <= 1'b1;
      r_vsyn      <= 1'b1;
      r_line_stb  <= 1'b0;
      r_frame_stb <= 1'b0;
`ifdef VTG_CSYNC_EN
      r_csyn      <= 1'b1;
`endif
    end else begin
      r_line_stb  <= CE_PIX && w_h_last;
      r_frame_stb <= CE_PIX && w_h_last && w_v_last;
      if (CE_PIX) begin
        r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
        if (w_h_last)
          r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        // Offsets only move on the last pixel of the frame so a pulse is never torn.
        if (w_h_last && w_v_last) begin
          r_hoffs_l <= HOFFS;
          r_voffs_l <= VOFFS;
        end
        r_hblk <= w_hblk;
        r_vblk <= w_vblk;
        r_hsyn <= !w_hs_on;
        r_vsyn <= !w_vs_on;
        r_rgb  <= (w_hblk || w_vblk) ? '0 : iRGB;
`ifdef VTG_CSYNC_EN
        r_csyn <= w_vs_on ? w_hs_on : !w_hs_on;
`endif
      end
    end
  assign HPOS      = r_hcnt - CNT_W'(H_ACT_START);
  assign VPOS      = r_vcnt;
  assign oRGB      = r_rgb;
  assign HBLK      = r_hblk;
  assign VBLK      = r_vblk;
  assign HSYN      = r_hsyn;
  assign VSYN      = r_vsyn;
  assign LINE_STB  = r_line_stb;
  assign FRAME_STB = r_frame_stb;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: vector and sequence checks on three video_timing_gen instances sharing one clock.
`timescale 1ns/1ps
module tb_video_timing_gen;
  logic MCLK = 1'b0, RESET = 1'b1, CE_PIX = 1'b0;
  logic [11:0] rgb = 12'hFFF;
  logic [4:0] d_hoffs = '0, v_hoffs = '0;
  logic [2:0] d_voffs = '0, h_voffs = '0, v_voffs = '0;
  logic [7:0] h_hoffs = '0;
  logic [8:0] d_hpos, d_vpos, h_hpos, h_vpos, v_hpos, v_vpos;
  logic [11:0] d_orgb, h_orgb, v_orgb;
  logic d_hblk, d_vblk, d_hsyn, d_vsyn, d_lstb, d_fstb;
  logic h_hblk, h_vblk, h_hsyn, h_vsyn, h_lstb, h_fstb;
  logic v_hblk, v_vblk, v_hsyn, v_vsyn, v_lstb, v_fstb;
`ifdef VTG_CSYNC_EN
  logic d_csyn, h_csyn, v_csyn;
`endif
  int n_chk = 0, n_fail = 0, n = 0;
  always #5 MCLK = ~MCLK;

  video_timing_gen u_dut (
    .MCLK(MCLK), .RESET(RESET), .CE_PIX(CE_PIX), .HOFFS(d_hoffs), .VOFFS(d_voffs), .iRGB(rgb),
    .HPOS(d_hpos), .VPOS(d_vpos), .oRGB(d_orgb), .HBLK(d_hblk), .VBLK(d_vblk), .HSYN(d_hsyn),
    .VSYN(d_vsyn), .LINE_STB(d_lstb), .FRAME_STB(d_fstb)
`ifdef VTG_CSYNC_EN
    , .CSYN(d_csyn)
`endif
  );
  // Default line, short frame: offset latching happens every 1536 CEs.
  video_timing_gen #(.HOFFS_W(8), .V_TOTAL(4), .V_ACT(2), .V_SYNC_BASE(2), .V_SYNC_W(1)) u_h (
    .MCLK(MCLK), .RESET(RESET), .CE_PIX(CE_PIX), .HOFFS(h_hoffs), .VOFFS(h_voffs), .iRGB(rgb),
    .HPOS(h_hpos), .VPOS(h_vpos), .oRGB(h_orgb), .HBLK(h_hblk), .VBLK(h_vblk), .HSYN(h_hsyn),
    .VSYN(h_vsyn), .LINE_STB(h_lstb), .FRAME_STB(h_fstb)
`ifdef VTG_CSYNC_EN
    , .CSYN(h_csyn)
`endif
  );
  // Default frame, 24-pixel line: a frame is 6336 CEs.
  video_timing_gen #(.H_TOTAL(24), .H_ACT_START(2), .H_ACT_END(18), .H_SYNC_BASE(19), .H_SYNC_W(3)) u_v (
    .MCLK(MCLK), .RESET(RESET), .CE_PIX(CE_PIX), .HOFFS(v_hoffs), .VOFFS(v_voffs), .iRGB(rgb),
    .HPOS(v_hpos), .VPOS(v_vpos), .oRGB(v_orgb), .HBLK(v_hblk), .VBLK(v_vblk), .HSYN(v_hsyn),
    .VSYN(v_vsyn), .LINE_STB(v_lstb), .FRAME_STB(v_fstb)
`ifdef VTG_CSYNC_EN
    , .CSYN(v_csyn)
`endif
  );

  typedef struct {
    int n;
    logic [11:0] rgb;
    logic [8:0] hpos, vpos;
    logic hblk, vblk, hsyn, lstb;
    logic [11:0] orgb;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(negedge MCLK);
    n++;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    CE_PIX = 1'b0;
    repeat (3) @(negedge MCLK);
    RESET = 1'b0;
    CE_PIX = 1'b1;
    n = 0;
  endtask

  task automatic pulse4;
    CE_PIX = 1'b0;
    repeat (3) @(negedge MCLK);
    CE_PIX = 1'b1;
    @(negedge MCLK);
    CE_PIX = 1'b0;
  endtask

  // Scan 384 CEs whose registered hcnt runs 200..583 (mod 384) on u_h.
  task automatic hwin(input int n0, input int hs_exp, input string tag);
    int lows = 0, falls = 0, first = -1;
    logic prev = 1'b1;
    while (n < n0) step();
    for (int i = 0; i < 384; i++) begin
      if (!h_hsyn) begin
        lows++;
        if (first < 0) first = (200 + i) % 384;
      end
      if (prev && !h_hsyn) falls++;
      prev = h_hsyn;
      step();
    end
    chk({tag, " width"}, lows, 32);
    chk({tag, " pulses"}, falls, 1);
    chk({tag, " start"}, first, hs_exp);
  endtask

  initial begin
    int cnt;
    int fall[$], rise[$], fstb[$];
    logic pv;
    vt[0]  = '{0,   12'hFFF, 9'd496, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
    vt[1]  = '{16,  12'hFFF, 9'd0,   9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
    vt[2]  = '{17,  12'hFFF, 9'd1,   9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF};
    vt[3]  = '{100, 12'hA5C, 9'd84,  9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hA5C};
    vt[4]  = '{272, 12'h123, 9'd256, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123};
    vt[5]  = '{273, 12'hFFF, 9'd257, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
    vt[6]  = '{288, 12'hFFF, 9'd272, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
    vt[7]  = '{289, 12'hFFF, 9'd273, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    vt[8]  = '{320, 12'hFFF, 9'd304, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    vt[9]  = '{321, 12'hFFF, 9'd305, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
    vt[10] = '{384, 12'hFFF, 9'd496, 9'd1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
    vt[11] = '{385, 12'hFFF, 9'd497, 9'd1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
    vt[12] = '{401, 12'hFFF, 9'd1,   9'd1, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      rgb = vt[i].rgb;
      while (n < vt[i].n) step();
      chk($sformatf("v%0d hpos", i), d_hpos, vt[i].hpos);
      chk($sformatf("v%0d vpos", i), d_vpos, vt[i].vpos);
      chk($sformatf("v%0d hblk", i), d_hblk, vt[i].hblk);
      chk($sformatf("v%0d vblk", i), d_vblk, vt[i].vblk);
      chk($sformatf("v%0d hsyn", i), d_hsyn, vt[i].hsyn);
      chk($sformatf("v%0d vsyn", i), d_vsyn, 1'b1);
      chk($sformatf("v%0d line_stb", i), d_lstb, vt[i].lstb);
      chk($sformatf("v%0d orgb", i), d_orgb, vt[i].orgb);
    end
    rgb = 12'hFFF;
    while (!d_lstb && n < 2000) step();
    chk("line_stb second", n, 768);
    cnt = 0;
    do begin step(); cnt++; end while (!d_lstb && cnt < 1000);
    chk("line_stb period", cnt, 384);

    // Mid-frame reset with CE every 4th clock at hcnt=200, vcnt=50.
    while (n < 50 * 384 + 190) step();
    for (int i = 0; i < 10; i++) pulse4();
    chk("pre-reset hpos", d_hpos, 184);
    chk("pre-reset vpos", d_vpos, 50);
    chk("pre-reset hblk", d_hblk, 1'b0);
    chk("pre-reset orgb", d_orgb, 12'hFFF);
    @(negedge MCLK);
    chk("ce low hold hpos", d_hpos, 184);
    chk("ce low line_stb", d_lstb, 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk("async hpos", d_hpos, 496);
    chk("async vpos", d_vpos, 0);
    chk("async hblk", d_hblk, 1'b1);
    chk("async vblk", d_vblk, 1'b1);
    chk("async hsyn", d_hsyn, 1'b1);
    chk("async vsyn", d_vsyn, 1'b1);
    chk("async orgb", d_orgb, 12'h000);
    chk("async strobes", {d_lstb, d_fstb}, 2'b00);
    repeat (3) @(negedge MCLK);
    RESET = 1'b0;
    cnt = 0;
    do begin pulse4(); cnt++; end while (!d_lstb && cnt < 1000);
    chk("restart first line", cnt, 384);
    chk("restart hpos", d_hpos, 496);
    chk("restart vpos", d_vpos, 1);
    @(negedge MCLK);
    chk("line_stb one clock", d_lstb, 1'b0);
    cnt = 0;
    do begin pulse4(); cnt++; end while (!d_lstb && cnt < 1000);
    chk("ce4 line period", cnt, 384);

    // Horizontal offsets on u_h: latched only at frame end.
    h_hoffs = 8'd31;
    do_reset();
    hwin(201, 288, "frame0 hoffs0");
    hwin(1536 + 201, 350, "hoffs31");
    h_hoffs = 8'd40;
    hwin(1536 + 201 + 768, 350, "hoffs40 same frame");
    hwin(3072 + 201, 368, "hoffs40 wrap");

    // Vertical timing on u_v: VOFFS 0 -> 7 during line 100 of frame 0.
    v_voffs = 3'd0;
    do_reset();
    pv = 1'b1;
    while (n < 12680) begin
      step();
      if (n == 2401) v_voffs = 3'd7;
      if (pv && !v_vsyn) fall.push_back(n);
      if (!pv && v_vsyn) rise.push_back(n);
      pv = v_vsyn;
      if (v_fstb) fstb.push_back(n);
      if (n == 5376) chk("vblk line223", v_vblk, 1'b0);
      if (n == 5377) chk("vblk line224", v_vblk, 1'b1);
`ifdef VTG_CSYNC_EN
      if (n >= 241 && n <= 264) chk("csyn line10", v_csyn, v_hsyn);
      if (n >= 5449 && n <= 5472) chk("csyn line227", v_csyn, !v_hsyn);
`endif
    end
    chk("vsync falls", fall.size(), 2);
    chk("vsync rises", rise.size(), 2);
    if (fall.size() == 2 && rise.size() == 2) begin
      chk("vsync f0 start", fall[0], 5425);
      chk("vsync f0 end", rise[0], 5521);
      chk("vsync f1 start", fall[1], 12433);
      chk("vsync f1 end", rise[1], 12529);
    end
    chk("frame_stb count", fstb.size(), 2);
    if (fstb.size() == 2) begin
      chk("frame_stb first", fstb[0], 6336);
      chk("frame_stb period", fstb[1] - fstb[0], 6336);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for arcade cores; successor to the fixed 9-bit per-core H/V generator.
- Runs on the system clock with a pixel clock-enable rather than a derived pixel clock.
- Produces pixel coordinates for the game core, registered blanking, syncs and blanked RGB for the video pipeline.
- Adds programmable totals and active windows, frame-synchronous offset loading, sync wrap-around, and line/frame strobes.

Parameters:
- CNT_W, 9: width of H/V counters and HPOS/VPOS.
- H_TOTAL, 384: pixel clocks per line.
- H_ACT_START, 16: first active hcnt.
- H_ACT_END, 272: first blanked hcnt after active (exclusive).
- V_TOTAL, 264: lines per frame.
- V_ACT, 224: active lines, vcnt 0..V_ACT-1.
- H_SYNC_BASE, 288: HSYNC start at zero offset.
- H_SYNC_W, 32: HSYNC width, pixels.
- V_SYNC_BASE, 226: VSYNC start line at zero offset.
- V_SYNC_W, 4: VSYNC width, lines.
- RGB_W, 12: RGB bus width.
- HOFFS_W, 5: H offset width; step is 2 pixels.
- VOFFS_W, 3: V offset width; step is 4 lines.

Ports:
- MCLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-high.
- CE_PIX  in  1  pixel enable; all counters and outputs advance only when high.
- HOFFS  in  HOFFS_W  horizontal sync offset.
- VOFFS  in  VOFFS_W  vertical sync offset.
- iRGB  in  RGB_W  pixel colour from the core.
- HPOS  out  CNT_W  hcnt - H_ACT_START, modulo 2^CNT_W.
- VPOS  out  CNT_W  vcnt.
- oRGB  out  RGB_W  registered colour, forced to 0 while blanking.
- HBLK  out  1  horizontal blank, registered.
- VBLK  out  1  vertical blank, registered.
- HSYN  out  1  horizontal sync, active-low.
- VSYN  out  1  vertical sync, active-low.
- LINE_STB  out  1  one CE-qualified pulse when hcnt wraps to 0.
- FRAME_STB  out  1  one CE-qualified pulse when hcnt=0 and vcnt=0.

Behaviour:
- Reset (async): hcnt=vcnt=0, HBLK=VBLK=1, HSYN=VSYN=1, oRGB=0, strobes=0.
  - Latched offsets are cleared to 0.
  - Reset mid-frame restarts at line 0, pixel 0 on the first CE after release.
- Counters, on CE_PIX only:
  - hcnt runs 0..H_TOTAL-1 then wraps to 0.
  - On the wrap, vcnt increments; vcnt runs 0..V_TOTAL-1 then wraps to 0.
  - No mid-line counter jumps; sync position never changes the line length.
- HPOS/VPOS: combinational from the counters, so zero latency.
- Registered outputs (one CE of latency relative to the counters, evaluated on the current hcnt/vcnt):
  - HBLK = !(H_ACT_START <= hcnt < H_ACT_END).
  - VBLK = !(vcnt < V_ACT).
  - oRGB = (HBLK_next | VBLK_next) ? 0 : iRGB.
- Sync positions:
  - hs_b = (H_SYNC_BASE + 2*hoffs_l) mod H_TOTAL.
  - vs_b = (V_SYNC_BASE + 4*voffs_l) mod V_TOTAL.
  - HSYN is low for H_SYNC_W consecutive hcnt values starting at hs_b, wrapping past H_TOTAL-1 to 0.
  - VSYN is low for V_SYNC_W lines starting at vs_b, with the same wrap rule.
  - VSYN changes only on a line boundary, with the registered HSYN/HBLK of hcnt=0.
- Offset latching: HOFFS/VOFFS are sampled into hoffs_l/voffs_l only on the CE where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
  - Mid-frame changes take effect from the next frame; no torn or doubled sync pulse.
- Strobes: LINE_STB and FRAME_STB are registered and high for exactly one MCLK.
  - They assert on the MCLK following the CE that moves the counter to the stated position.
- Arithmetic: internal sums use CNT_W+2 bits before the modulo reduction.
  - Parameters must satisfy H_ACT_END <= H_TOTAL <= 2^CNT_W and V_ACT <= V_TOTAL <= 2^CNT_W.
- CE_PIX low: all state and outputs hold; strobes are 0.

Optional Feature:
- VTG_CSYNC_EN.
- Defined: adds output CSYN (1 bit, reset 1).
  - Outside the VSYNC window, CSYN = HSYN.
  - Inside the VSYNC window, CSYN = !HSYN (serration, inverted H pulses).
  - Registered with the other syncs.
- Not defined: port absent, no extra logic.

Test Plan:
- Reset release with CE_PIX=1 every clock, defaults:
  - HBLK falls one CE after hcnt=16 and rises one CE after hcnt=272: 256 active pixels.
  - LINE_STB period is 384 CEs.
  - FRAME_STB period is 101376 CEs.
- HOFFS=0, VOFFS=0:
  - HSYN low for hcnt 288..319 on every line.
  - VSYN low for lines 226..229.
  - iRGB=12'hFFF, so oRGB=0 on every blanked pixel.
- HOFFS=31 (hs_b=350, spans 350..381), then HOFFS=40 via an 8-bit-wide override bench (hs_b=368, wraps 368..383, 0..15):
  - HSYN low for exactly 32 CEs in both cases, no glitch at the wrap.
- VOFFS changed from 0 to 7 at line 100:
  - Current frame VSYN stays at lines 226..229.
  - Next frame VSYN at lines 254..257.
- CE_PIX toggling every 4th clock, with RESET asserted for 3 clocks at hcnt=200, vcnt=50:
  - Outputs go to reset values immediately.
  - Counting resumes from 0,0; line length stays 384 CEs.
- VTG_CSYNC_EN defined: CSYN equals HSYN on line 10 and equals !HSYN on line 227.
